// File: rtl/cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// cache_tag_ctrl
//   Controller for a direct-mapped cache tag RAM with a synchronous read port.
//   It accepts CPU lookups and compares the stored tag to report hit or miss.
//   On a miss it optionally writes back a dirty victim line, then fills the
//   line through a request/ack memory handshake, and finally rewrites the tag.
//   Tag RAM entry layout: {valid, dirty, tag[TAG_W-1:0]}.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready CPU request handshake
//   req_addr            {tag, index, offset}
//   req_write           write access (marks the line dirty)
//   resp_valid          one-cycle response strobe
//   resp_hit            1 = hit, 0 = miss that has been serviced
//   tag_addr/din/we     tag RAM address, write data, write enable
//   tag_dout            tag RAM read data (one cycle after address sampled)
//   mem_req/mem_wb      memory request, held until mem_ack; wb=1 writeback
//   mem_addr            line address with the offset bits forced to zero
//   mem_ack             single-cycle completion pulse from memory
// -----------------------------------------------------------------------------
module cache_tag_ctrl #(
    parameter int AWIDTH         = 3,
    parameter int DWIDTH         = 14,
    parameter int OFFSET_W       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 req_valid,
    input  logic [DWIDTH-2+AWIDTH+OFFSET_W-1:0]  req_addr,
    input  logic                                 req_write,
    output logic                                 req_ready,
    output logic                                 resp_valid,
    output logic                                 resp_hit,
    output logic [AWIDTH-1:0]                    tag_addr,
    output logic [DWIDTH-1:0]                    tag_din,
    output logic                                 tag_we,
    input  logic [DWIDTH-1:0]                    tag_dout,
    output logic                                 mem_req,
    output logic                                 mem_wb,
    output logic [DWIDTH-2+AWIDTH+OFFSET_W-1:0]  mem_addr,
    input  logic                                 mem_ack
);

    localparam int TAG_W  = DWIDTH - 2;
    localparam int ADDR_W = TAG_W + AWIDTH + OFFSET_W;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_LOOKUP    = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FILL      = 3'd4,
        S_UPDATE    = 3'd5
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;

    state_t              state, state_n;
    logic [AWIDTH-1:0]   init_cnt;
    logic [TAG_W-1:0]    lat_tag;
    logic [AWIDTH-1:0]   lat_idx;
    logic                lat_write;
    logic [TAG_W-1:0]    victim_tag;

    logic [TAG_W-1:0]    req_tag;
    logic [AWIDTH-1:0]   req_idx;
    logic                lookup_hit;
    logic                victim_dirty;
    logic                unused_offset;

    assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx       = req_addr[OFFSET_W +: AWIDTH];
    // Offset bits select a word within the line and play no part in tagging.
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Only meaningful in LOOKUP, where tag_dout reflects the latched index.
    assign lookup_hit   = tag_dout[DWIDTH-1] && (tag_dout[TAG_W-1:0] == lat_tag);
    assign victim_dirty = tag_dout[DWIDTH-1] && tag_dout[DWIDTH-2];

    // Next state and outputs. While reset is high every output is forced to
    // its idle value, so an in-flight memory request drops immediately rather
    // than waiting for the state register to settle.
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        tag_addr  = '0;
        tag_din   = '0;
        tag_we    = 1'b0;
        mem_req   = 1'b0;
        mem_wb    = 1'b0;
        mem_addr  = '0;
        if (!reset) begin
            case (state)
                S_INIT: begin
                    tag_we   = 1'b1;
                    tag_addr = init_cnt;
                    if (init_cnt == {AWIDTH{1'b1}}) state_n = S_IDLE;
                end
                S_IDLE: begin
                    req_ready = 1'b1;
                    // Present the index straight away so the synchronous RAM
                    // returns the entry during LOOKUP.
                    tag_addr  = req_idx;
                    if (req_valid) state_n = S_LOOKUP;
                end
                S_LOOKUP: begin
                    tag_addr = lat_idx;
                    if (lookup_hit) begin
                        if (lat_write) begin
                            tag_we  = 1'b1;
                            tag_din = {2'b11, lat_tag};
                        end
                        state_n = S_IDLE;
                    end else if (victim_dirty) begin
                        state_n = S_WRITEBACK;
                    end else begin
                        state_n = S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    tag_addr = lat_idx;
                    mem_req  = 1'b1;
                    mem_wb   = 1'b1;
                    mem_addr = {victim_tag, lat_idx, {OFFSET_W{1'b0}}};
                    if (mem_ack) state_n = S_FILL;
                end
                S_FILL: begin
                    tag_addr = lat_idx;
                    mem_req  = 1'b1;
                    mem_addr = {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
                    if (mem_ack) state_n = S_UPDATE;
                end
                S_UPDATE: begin
                    tag_we   = 1'b1;
                    tag_addr = lat_idx;
                    tag_din  = {1'b1, lat_write, lat_tag};
                    state_n  = S_IDLE;
                end
                default: state_n = RST_STATE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RST_STATE;
            init_cnt   <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            victim_tag <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
        end else begin
            state      <= state_n;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            case (state)
                S_INIT: init_cnt <= init_cnt + 1'b1;
                S_IDLE: begin
                    if (req_valid) begin
                        lat_tag   <= req_tag;
                        lat_idx   <= req_idx;
                        lat_write <= req_write;
                    end
                end
                S_LOOKUP: begin
                    // Capture the victim now; the RAM output is not relied on
                    // once the controller leaves LOOKUP.
                    victim_tag <= tag_dout[TAG_W-1:0];
                    if (lookup_hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                    end
                end
                S_UPDATE: resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_ctrl
//   Directed bench for cache_tag_ctrl at default parameters. Contains a small
//   synchronous-read tag RAM and a memory responder. A vector table covers
//   hit, clean miss and dirty-miss sequences; hand-written sequences cover the
//   reset sweep, back-to-back hits, a stalled fill and reset during writeback.
// -----------------------------------------------------------------------------
module tb_cache_tag_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic        req_write = 1'b0;
    logic        mem_ack = 1'b0;
    logic        req_ready, resp_valid, resp_hit, tag_we, mem_req, mem_wb;
    logic [2:0]  tag_addr;
    logic [13:0] tag_din;
    logic [13:0] tag_dout;
    logic [15:0] mem_addr;

    logic [13:0] ram [8];

    int checks = 0;
    int errors = 0;

    cache_tag_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .tag_addr(tag_addr), .tag_din(tag_din), .tag_we(tag_we), .tag_dout(tag_dout),
        .mem_req(mem_req), .mem_wb(mem_wb), .mem_addr(mem_addr), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    // Tag RAM: read-old-data synchronous RAM; preload fills non-zero garbage.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) ram[i] <= 14'h3FF0 | 14'(i);
        end else if (tag_we) begin
            ram[tag_addr] <= tag_din;
        end
        tag_dout <= ram[tag_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expect the clearing sweep starting right after reset deassertion.
    task automatic check_sweep(input string nm);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("%s_init%0d", nm, k),
                64'({tag_we, tag_addr, tag_din, req_ready, resp_valid, mem_req}),
                64'({1'b1, 3'(k), 14'h0, 1'b0, 1'b0, 1'b0}));
            @(negedge clock);
        end
        #1;
        chk($sformatf("%s_ready", nm), 64'({req_ready, tag_we, resp_valid}), 64'(3'b100));
    endtask

    // One complete CPU transaction with an automatic memory responder.
    task automatic do_req(input logic [15:0] a, input logic w, input int ack_dly,
                          output logic got, output logic hit, output int lat,
                          output logic swb, output logic [15:0] wba,
                          output logic sfl, output logic [15:0] fla,
                          output logic stable);
        int   n;
        int   waitn;
        logic ackp;
        got = 0; hit = 0; lat = 0; swb = 0; wba = 0; sfl = 0; fla = 0;
        stable = 1; waitn = 0;
        @(negedge clock);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        req_valid = 1'b1; req_addr = a; req_write = w;
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            ackp = mem_ack;
            mem_ack = 1'b0;
            if (resp_valid) begin
                got = 1; hit = resp_hit; lat = k;
            end else begin
                if (mem_req) begin
                    if (req_ready) stable = 0;
                    if (mem_wb) begin
                        if (swb && mem_addr !== wba) stable = 0;
                        swb = 1; wba = mem_addr;
                    end else begin
                        if (sfl && mem_addr !== fla) stable = 0;
                        sfl = 1; fla = mem_addr;
                    end
                    if (!ackp) begin
                        if (waitn >= ack_dly) begin
                            mem_ack = 1'b1; waitn = 0;
                        end else begin
                            waitn++;
                        end
                    end
                end
                @(negedge clock);
            end
        end
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        hit;
        logic        wb;
        logic [15:0] wb_addr;
        logic [15:0] fill_addr;
        logic [13:0] entry;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic        got, hit, swb, sfl, stable, ok;
        logic [15:0] wba, fla;
        logic [2:0]  idx;
        int          lat;

        //          addr      wr  hit wb  wb_addr   fill_addr entry
        vecs[0]  = '{16'h1234, 0, 0, 0, 16'h0000, 16'h1234, 14'h2123};
        vecs[1]  = '{16'h1234, 0, 1, 0, 16'h0000, 16'h0000, 14'h2123};
        vecs[2]  = '{16'h1235, 1, 1, 0, 16'h0000, 16'h0000, 14'h3123};
        vecs[3]  = '{16'hABC4, 0, 0, 1, 16'h1234, 16'hABC4, 14'h2ABC};
        vecs[4]  = '{16'h0010, 1, 0, 0, 16'h0000, 16'h0010, 14'h3001};
        vecs[5]  = '{16'h0011, 0, 1, 0, 16'h0000, 16'h0000, 14'h3001};
        vecs[6]  = '{16'hF010, 0, 0, 1, 16'h0010, 16'hF010, 14'h2F01};
        vecs[7]  = '{16'hABC5, 0, 1, 0, 16'h0000, 16'h0000, 14'h2ABC};
        vecs[8]  = '{16'hFFFE, 1, 0, 0, 16'h0000, 16'hFFFE, 14'h3FFF};
        vecs[9]  = '{16'h7FFE, 0, 0, 1, 16'hFFFE, 16'h7FFE, 14'h27FF};
        vecs[10] = '{16'h7FFF, 1, 1, 0, 16'h0000, 16'h0000, 14'h37FF};
        vecs[11] = '{16'hFFFF, 0, 0, 1, 16'h7FFE, 16'hFFFE, 14'h2FFF};

        // T1: reset values, then the clearing sweep.
        @(negedge clock);
        @(negedge clock);
        preload = 1'b0;
        @(negedge clock);
        chk("reset_ctrl", 64'({req_ready, resp_valid, resp_hit, tag_we, mem_req, mem_wb}), 64'(0));
        chk("reset_bus", 64'({tag_addr, tag_din, mem_addr}), 64'(0));
        reset = 1'b0;
        check_sweep("t1");
        ok = 1;
        for (int i = 0; i < 8; i++) if (ram[i] !== 14'h0) ok = 0;
        chk("t1_ram_cleared", 64'(ok), 64'(1));

        // T2..T4 and further patterns from the table.
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].addr, vecs[i].wr, i % 3, got, hit, lat, swb, wba, sfl, fla, stable);
            chk($sformatf("v%0d_resp", i), 64'({got, hit}), 64'({1'b1, vecs[i].hit}));
            if (vecs[i].hit) chk($sformatf("v%0d_latency", i), 64'(lat), 64'(1));
            chk($sformatf("v%0d_wb", i), 64'({swb, wba}), 64'({vecs[i].wb, vecs[i].wb_addr}));
            chk($sformatf("v%0d_fill", i), 64'({sfl, fla}), 64'({~vecs[i].hit, vecs[i].fill_addr}));
            chk($sformatf("v%0d_stable", i), 64'(stable), 64'(1));
            idx = vecs[i].addr[3:1];
            chk($sformatf("v%0d_entry", i), 64'(ram[idx]), 64'(vecs[i].entry));
        end

        // Back-to-back hits: accept in the same cycle the first response shows.
        @(negedge clock);
        req_valid = 1'b1; req_addr = 16'hFFFE; req_write = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_lookup1", 64'({resp_valid, req_ready}), 64'(2'b00));
        @(negedge clock);
        chk("b2b_resp1", 64'({resp_valid, resp_hit, req_ready}), 64'(3'b111));
        req_valid = 1'b1; req_addr = 16'hF010;
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_accept2", 64'({resp_valid, req_ready, mem_req}), 64'(3'b000));
        @(negedge clock);
        chk("b2b_resp2", 64'({resp_valid, resp_hit}), 64'(2'b11));

        // T5: stalled fill, invalid entry with a matching stored tag of zero.
        @(negedge clock);
        req_valid = 1'b1; req_addr = 16'h0006; req_write = 1'b0;
        @(negedge clock);
        req_addr = 16'h1236;      // held valid while busy: must be ignored
        @(negedge clock);
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            if (!(mem_req === 1'b1 && mem_wb === 1'b0 && mem_addr === 16'h0006 &&
                  req_ready === 1'b0 && resp_valid === 1'b0)) ok = 0;
            @(negedge clock);
        end
        chk("t5_stall", 64'(ok), 64'(1));
        req_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("t5_update", 64'({mem_req, tag_we, tag_addr, tag_din}), 64'({1'b0, 1'b1, 3'd3, 14'h2000}));
        @(negedge clock);
        chk("t5_resp", 64'({resp_valid, resp_hit}), 64'(2'b10));
        chk("t5_entry", 64'(ram[3]), 64'(14'h2000));
        @(negedge clock);
        chk("t5_no_queue", 64'({resp_valid, mem_req, req_ready}), 64'(3'b001));

        // T6: dirty the line, then reset during the writeback.
        do_req(16'hABC4, 1'b1, 0, got, hit, lat, swb, wba, sfl, fla, stable);
        chk("t6_dirty_hit", 64'({got, hit, swb, sfl}), 64'(4'b1100));
        chk("t6_dirty_entry", 64'(ram[2]), 64'(14'h3ABC));
        @(negedge clock);
        req_valid = 1'b1; req_addr = 16'h1234; req_write = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("t6_in_wb", 64'({mem_req, mem_wb, mem_addr}), 64'({2'b11, 16'hABC4}));
        reset = 1'b1;
        #1;
        chk("t6_req_drop", 64'({mem_req, mem_wb, resp_valid, tag_we}), 64'(0));
        ok = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) ok = 0;
        end
        chk("t6_quiet_in_reset", 64'(ok), 64'(1));
        reset = 1'b0;
        check_sweep("t6");
        chk("t6_entry_cleared", 64'(ram[2]), 64'(14'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
